hazard_stall_unit: RTL and testbench

Pipeline hazard controller for the 5-stage pipelined CPU. It is the counterpart to operand forwarding: it handles the cases forwarding cannot resolve.
- Load-use hazards: stalls IF/ID and inserts a bubble into ID/EX.
- Taken branches resolved in EX: flushes wrong-path instructions for a parameterised number of cycles.
- Data-memory wait: freezes the whole pipeline.
- Maintains a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit_if.sv | 30 +++
 rtl/hazard_stall_unit.sv | 74 +++++++
 tb/tb_hazard_stall_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: hazard detection inputs from the pipeline and stall/flush controls back to it.
interface hazard_stall_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic MemRead_ex;
  logic [REG_W-1:0] Rd_ex;
  logic [REG_W-1:0] regA_id;
  logic [REG_W-1:0] regB_id;
  logic useA_id;
  logic useB_id;
  logic br_taken_ex;
  logic dmem_wait;
  logic cnt_clear;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble;
  logic pipe_hold;
  logic busy;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output MemRead_ex, Rd_ex, regA_id, regB_id, useA_id, useB_id, br_taken_ex, dmem_wait, cnt_clear,
    input pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, busy, stall_count
  );
  modport slave (
    input MemRead_ex, Rd_ex, regA_id, regB_id, useA_id, useB_id, br_taken_ex, dmem_wait, cnt_clear,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, busy, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stalls, taken-branch flushes, memory-wait freeze and a saturating stall counter.
module hazard_stall_unit #(
  parameter int REG_W = 5,
  parameter int ZERO_REG = 31,
  parameter int BR_FLUSH = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_stall_unit_if.slave hz
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, nextState;
  logic [2:0] fcnt, nextFcnt;
  logic [CNT_W-1:0] stallCnt;
  logic luHit, stallCyc;
  assign luHit = hz.MemRead_ex && (hz.Rd_ex != REG_W'(ZERO_REG)) &&
                 ((hz.useA_id && hz.regA_id == hz.Rd_ex) || (hz.useB_id && hz.regB_id == hz.Rd_ex));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      fcnt <= '0;
    end else begin
      state <= nextState;
      fcnt <= nextFcnt;
    end
  // Reset forces a NOP into both front registers while the PC is held.
  always_comb begin
    nextState = state;
    nextFcnt = fcnt;
    hz.pc_write = 1'b1;
    hz.ifid_write = 1'b1;
    hz.ifid_flush = 1'b0;
    hz.idex_bubble = 1'b0;
    hz.pipe_hold = 1'b0;
    stallCyc = 1'b0;
    if (!rst_n) begin
      hz.pc_write = 1'b0;
      hz.ifid_write = 1'b0;
      hz.ifid_flush = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (hz.dmem_wait) begin
      hz.pipe_hold = 1'b1;
      hz.pc_write = 1'b0;
      hz.ifid_write = 1'b0;
      stallCyc = 1'b1;
    end else if (state == FLUSH) begin
      hz.ifid_flush = 1'b1;
      hz.idex_bubble = 1'b1;
      stallCyc = 1'b1;
      nextFcnt = fcnt - 3'd1;
      nextState = (fcnt == 3'd1) ? RUN : FLUSH;
    end else if (hz.br_taken_ex) begin
      hz.ifid_flush = 1'b1;
      hz.idex_bubble = 1'b1;
      stallCyc = 1'b1;
      if (BR_FLUSH > 1) begin
        nextState = FLUSH;
        nextFcnt = 3'(BR_FLUSH - 1);
      end
    end else if (luHit) begin
      hz.pc_write = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_bubble = 1'b1;
      stallCyc = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stallCnt <= '0;
    else if (hz.cnt_clear) stallCnt <= '0;
    else if (stallCyc && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
  assign hz.stall_count = stallCnt;
  assign hz.busy = (state == FLUSH);
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed test-plan cases then random cycles against a cycle-count reference model.
module tb_hazard_stall_unit;
  localparam int BR_FLUSH = 2;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  int flushLeft = 0;
  int expCnt = 0;
  hazard_stall_unit_if #(.REG_W(5), .CNT_W(CNT_W)) hz ();
  hazard_stall_unit #(.REG_W(5), .ZERO_REG(31), .BR_FLUSH(BR_FLUSH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hz(hz.slave)
  );
  always #5 clk = ~clk;
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Drive one cycle of inputs mid-period, check the combinational decode and counter, then advance the model.
  task automatic step(input logic rn, ml, input logic [4:0] rd, ra, rb,
                      input logic ua, ub, br, dw, clr);
    logic hit, stall;
    logic [5:0] expCtrl;
    @(negedge clk);
    rst_n = rn;
    hz.MemRead_ex = ml;
    hz.Rd_ex = rd;
    hz.regA_id = ra;
    hz.regB_id = rb;
    hz.useA_id = ua;
    hz.useB_id = ub;
    hz.br_taken_ex = br;
    hz.dmem_wait = dw;
    hz.cnt_clear = clr;
    #1;
    if (!rn) begin
      flushLeft = 0;
      expCnt = 0;
    end
    hit = ml && rd != 5'd31 && ((ua && ra == rd) || (ub && rb == rd));
    if (!rn) expCtrl = 6'b001100;
    else if (dw) expCtrl = {5'b00001, flushLeft > 0};
    else if (flushLeft > 0) expCtrl = 6'b111101;
    else if (br) expCtrl = 6'b111100;
    else if (hit) expCtrl = 6'b000100;
    else expCtrl = 6'b110000;
    checkVal("ctrl{pc,ifw,iff,bub,hold,busy}",
             32'({hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.pipe_hold, hz.busy}),
             32'(expCtrl));
    checkVal("stall_count", 32'(hz.stall_count), 32'(expCnt));
    if (rn) begin
      stall = dw || flushLeft > 0 || br || hit;
      if (!dw) begin
        if (flushLeft > 0) flushLeft--;
        else if (br) flushLeft = BR_FLUSH - 1;
      end
      if (clr) expCnt = 0;
      else if (stall && expCnt < CNT_MAX) expCnt++;
    end
  endtask
  task automatic idle(input logic clr);
    step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 0, clr);
  endtask
  initial begin
    logic [4:0] rd, ra, rb;
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0);
    idle(0);
    step(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    checkVal("lu_busy", 32'(hz.busy), 32'd0);
    idle(0);
    step(1, 1, 5'd31, 5'd31, 5'd0, 1, 0, 0, 0, 0);
    step(1, 1, 5'd7, 5'd0, 5'd7, 1, 0, 0, 0, 0);
    step(1, 0, 5'd7, 5'd7, 5'd7, 1, 1, 1, 0, 0);
    step(1, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 0, 0);
    idle(0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    idle(0);
    idle(0);
    step(1, 1, 5'd4, 5'd4, 5'd0, 1, 0, 1, 0, 0);
    idle(0);
    step(1, 1, 5'd4, 5'd0, 5'd4, 0, 1, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 20; i++) step(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    idle(0);
    checkVal("saturated", 32'(hz.stall_count), CNT_MAX);
    step(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 1);
    idle(0);
    checkVal("clear_wins", 32'(hz.stall_count), 32'd0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    checkVal("reset_mid_flush_busy", 32'(hz.busy), 32'd0);
    idle(0);
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      ra = ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 7));
      step($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)), rd, ra, rb,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
